// File: rtl/pwm_pkg.sv
// Shared types and default sizing for the H-bridge PWM sequencing controller.
package pwm_pkg;

  localparam int PWM_N            = 4;
  localparam int PWM_DEAD_PERIODS = 2;

  typedef enum logic [2:0] {
    IDLE,
    RAMP,
    HOLD,
    BRAKE,
    DEAD
  } ctrl_state_t;

  typedef enum logic {
    DIR_A = 1'b0,
    DIR_B = 1'b1
  } pwm_dir_t;

  function automatic logic is_busy(ctrl_state_t s);
    return (s == RAMP) || (s == BRAKE) || (s == DEAD);
  endfunction

endpackage

// File: rtl/dead_timer.sv
// Loadable down-counter advanced by pwm_step; done pulses on the step that takes it from 1 to 0.
module dead_timer #(
  parameter int W = 2
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic         step,
  output logic         done
);

  logic [W-1:0] count;

  always_ff @(posedge clk) begin
    if (rst) begin
      count <= '0;
    end else if (load) begin
      count <= load_val;
    end else if (step && (count != '0)) begin
      count <= count - W'(1);
    end
  end

  assign done = step && !load && (count == W'(1));

endmodule

// File: rtl/pwm_ramp_ctrl.sv
// Duty/direction/drive sequencer for the H-bridge PWM; reversals brake to zero and hold a dead time.
// Build option PWM_SOFTSTART_EN: duty ramps by RAMP_STEP per period; otherwise it jumps in one period.
//
// state | meaning
// IDLE  | drive off, duty 0
// RAMP  | duty moving toward the effective target
// HOLD  | duty settled on a nonzero target
// BRAKE | duty falling to 0 before a reversal
// DEAD  | drive off for DEAD_PERIODS periods
module pwm_ramp_ctrl
  import pwm_pkg::*;
#(
  parameter int N            = PWM_N,
  parameter int RAMP_STEP    = 1,
  parameter int DEAD_PERIODS = PWM_DEAD_PERIODS
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         ena,
  input  logic         pwm_step,
  input  logic [N-1:0] target_duty,
  input  logic         target_dir,
  output logic [N-1:0] duty,
  output logic         dir,
  output logic         drive_ena,
  output logic         busy
);

  localparam int DW = $clog2(DEAD_PERIODS + 1);

  if (DEAD_PERIODS < 1) begin : g_dead_chk
    $fatal(1, "pwm_ramp_ctrl: DEAD_PERIODS must be at least 1");
  end
  if ((RAMP_STEP < 1) || (RAMP_STEP > (2 ** N) - 1)) begin : g_step_chk
    $fatal(1, "pwm_ramp_ctrl: RAMP_STEP out of range");
  end

  ctrl_state_t  state_q, state_d;
  logic [N-1:0] duty_q, duty_d;
  pwm_dir_t     dir_q, dir_d;
  logic         drv_q, drv_d;
  logic [N-1:0] eff, ramp_nx, brake_nx;
  pwm_dir_t     tdir;
  logic         tmr_load, tmr_step, tmr_done;

  assign eff  = ena ? target_duty : '0;
  assign tdir = pwm_dir_t'(target_dir);

`ifdef PWM_SOFTSTART_EN
  localparam logic [N:0] STEP_X = (N+1)'(RAMP_STEP);
  logic [N:0] ext_duty, ext_tgt;
  assign ext_duty = {1'b0, duty_q};
  assign ext_tgt  = {1'b0, eff};

  // One extra bit keeps sums/differences from wrapping; results saturate at the target or 0.
  always_comb begin
    ramp_nx  = eff;
    brake_nx = '0;
    if (ext_duty < ext_tgt) begin
      if (ext_duty + STEP_X < ext_tgt) ramp_nx = N'(ext_duty + STEP_X);
    end else if (ext_duty > ext_tgt + STEP_X) begin
      ramp_nx = N'(ext_duty - STEP_X);
    end
    if (ext_duty > STEP_X) brake_nx = N'(ext_duty - STEP_X);
  end
`else
  assign ramp_nx  = eff;
  assign brake_nx = '0;
`endif

  always_comb begin
    state_d  = state_q;
    duty_d   = duty_q;
    dir_d    = dir_q;
    drv_d    = drv_q;
    tmr_load = 1'b0;
    tmr_step = 1'b0;
    if (pwm_step) begin
      case (state_q)
        IDLE: begin
          if (eff != '0) begin
            dir_d   = tdir;
            drv_d   = 1'b1;
            duty_d  = ramp_nx;
            state_d = RAMP;
          end
        end
        RAMP, HOLD: begin
          if ((state_q == RAMP) || (eff != duty_q) || (tdir != dir_q)) begin
            if ((tdir != dir_q) && (duty_q != '0)) begin
              state_d = BRAKE;
            end else begin
              duty_d = ramp_nx;
              if (ramp_nx != eff) begin
                state_d = RAMP;
              end else if (eff != '0) begin
                state_d = HOLD;
              end else begin
                state_d = IDLE;
                drv_d   = 1'b0;
              end
            end
          end
        end
        BRAKE: begin
          duty_d = brake_nx;
          if (brake_nx == '0) begin
            drv_d    = 1'b0;
            tmr_load = 1'b1;
            state_d  = DEAD;
          end
        end
        DEAD: begin
          tmr_step = 1'b1;
          if (tmr_done) begin
            dir_d = tdir;
            if (eff != '0) begin
              drv_d   = 1'b1;
              state_d = RAMP;
            end else begin
              state_d = IDLE;
            end
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      duty_q  <= '0;
      dir_q   <= DIR_A;
      drv_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      duty_q  <= duty_d;
      dir_q   <= dir_d;
      drv_q   <= drv_d;
    end
  end

  dead_timer #(
    .W(DW)
  ) u_dead_timer (
    .clk     (clk),
    .rst     (rst),
    .load    (tmr_load),
    .load_val(DW'(DEAD_PERIODS)),
    .step    (tmr_step),
    .done    (tmr_done)
  );

  assign duty      = duty_q;
  assign dir       = dir_q;
  assign drive_ena = drv_q;
  assign busy      = is_busy(state_q);

endmodule

// File: tb/tb_pwm_ramp_ctrl.sv
// Bench for pwm_ramp_ctrl: two instances (RAMP_STEP 1 and 3) checked every cycle against a period-level model.
module tb_pwm_ramp_ctrl;

  localparam int N  = 4;
  localparam int DP = 2;
`ifdef PWM_SOFTSTART_EN
  localparam int STEP0 = 1;
  localparam int STEP1 = 3;
`else
  localparam int STEP0 = 16;
  localparam int STEP1 = 16;
`endif

  typedef logic [6:0] exp_t;  // {duty[3:0], dir, drive_ena, busy}

  logic         clk = 1'b0;
  logic         rst, ena, pwm_step, target_dir;
  logic [N-1:0] target_duty;
  logic [N-1:0] duty_o [2];
  logic         dir_o  [2];
  logic         drv_o  [2];
  logic         busy_o [2];

  int checks = 0, errors = 0, cyc = 0;
  bit chk_en = 1'b0;

  int m_duty [2];
  int m_dead [2];
  bit m_dir [2], m_drv [2], m_moving [2], m_braking [2];

  exp_t ss_tab [4];
  exp_t rev_tab [10];
  exp_t drop_tab [3];

  always #5 clk = ~clk;

  pwm_ramp_ctrl #(.N(N), .RAMP_STEP(1), .DEAD_PERIODS(DP)) dut0 (
    .clk(clk), .rst(rst), .ena(ena), .pwm_step(pwm_step),
    .target_duty(target_duty), .target_dir(target_dir),
    .duty(duty_o[0]), .dir(dir_o[0]), .drive_ena(drv_o[0]), .busy(busy_o[0])
  );

  pwm_ramp_ctrl #(.N(N), .RAMP_STEP(3), .DEAD_PERIODS(DP)) dut1 (
    .clk(clk), .rst(rst), .ena(ena), .pwm_step(pwm_step),
    .target_duty(target_duty), .target_dir(target_dir),
    .duty(duty_o[1]), .dir(dir_o[1]), .drive_ena(drv_o[1]), .busy(busy_o[1])
  );

  function automatic exp_t E(int d, bit dr, bit dv, bit b);
    return {4'(d), dr, dv, b};
  endfunction

  function automatic int approach(int cur, int tgt, int s);
    if (cur < tgt) return (cur + s > tgt) ? tgt : cur + s;
    if (cur > tgt) return (cur - s < tgt) ? tgt : cur - s;
    return cur;
  endfunction

  // Period-level behaviour: active drive either moving, settled, braking, or counting dead periods.
  task automatic model_update(int i);
    int eff, s;
    if (rst) begin
      m_duty[i] = 0; m_dead[i] = 0; m_dir[i] = 0; m_drv[i] = 0;
      m_moving[i] = 0; m_braking[i] = 0;
      return;
    end
    if (!pwm_step) return;
    eff = ena ? int'(target_duty) : 0;
    s   = (i == 0) ? STEP0 : STEP1;
    if (m_dead[i] > 0) begin
      m_dead[i]--;
      if (m_dead[i] == 0) begin
        m_dir[i] = target_dir;
        if (eff != 0) begin
          m_drv[i] = 1; m_moving[i] = 1;
        end
      end
    end else if (m_braking[i]) begin
      m_duty[i] = (m_duty[i] > s) ? m_duty[i] - s : 0;
      if (m_duty[i] == 0) begin
        m_braking[i] = 0; m_drv[i] = 0; m_dead[i] = DP;
      end
    end else if (m_drv[i]) begin
      if (m_moving[i] || eff != m_duty[i] || target_dir != m_dir[i]) begin
        if (target_dir != m_dir[i] && m_duty[i] != 0) begin
          m_braking[i] = 1; m_moving[i] = 0;
        end else begin
          m_duty[i]   = approach(m_duty[i], eff, s);
          m_moving[i] = (m_duty[i] != eff);
          if (m_duty[i] == 0 && eff == 0) m_drv[i] = 0;
        end
      end
    end else if (eff != 0) begin
      m_dir[i] = target_dir; m_drv[i] = 1; m_moving[i] = 1;
      m_duty[i] = approach(0, eff, s);
    end
  endtask

  always @(posedge clk) begin
    for (int i = 0; i < 2; i++) model_update(i);
  end

  task automatic chk(string nm, logic [7:0] got, logic [7:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", nm, got, exp);
    end
  endtask

  task automatic lit(string nm, int i, exp_t e);
    chk($sformatf("%s.u%0d.duty", nm, i), 8'(duty_o[i]), 8'(e[6:3]));
    chk($sformatf("%s.u%0d.dir", nm, i), 8'(dir_o[i]), 8'(e[2]));
    chk($sformatf("%s.u%0d.drive_ena", nm, i), 8'(drv_o[i]), 8'(e[1]));
    chk($sformatf("%s.u%0d.busy", nm, i), 8'(busy_o[i]), 8'(e[0]));
  endtask

  always @(negedge clk) begin
    cyc++;
    if (chk_en) begin
      for (int i = 0; i < 2; i++) begin
        chk($sformatf("c%0d.u%0d.duty", cyc, i), 8'(duty_o[i]), 8'(m_duty[i]));
        chk($sformatf("c%0d.u%0d.dir", cyc, i), 8'(dir_o[i]), 8'(m_dir[i]));
        chk($sformatf("c%0d.u%0d.drive_ena", cyc, i), 8'(drv_o[i]), 8'(m_drv[i]));
        chk($sformatf("c%0d.u%0d.busy", cyc, i), 8'(busy_o[i]),
            8'(m_moving[i] || m_braking[i] || (m_dead[i] > 0)));
      end
    end
  end

  // One PWM period: step pulse, then two idle cycles with the inputs scrambled and restored.
  task automatic do_step(int n);
    logic [N-1:0] sv_t;
    logic         sv_d;
    for (int k = 0; k < n; k++) begin
      @(negedge clk); pwm_step = 1'b1;
      @(negedge clk); pwm_step = 1'b0;
      sv_t = target_duty; sv_d = target_dir;
      target_duty = ~sv_t; target_dir = ~sv_d;
      @(negedge clk);
      target_duty = sv_t; target_dir = sv_d;
    end
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
`ifdef PWM_SOFTSTART_EN
    ss_tab   = '{E(1,0,1,1), E(2,0,1,1), E(3,0,1,1), E(4,0,1,0)};
    rev_tab  = '{E(4,0,1,1), E(3,0,1,1), E(2,0,1,1), E(1,0,1,1), E(0,0,0,1),
                 E(0,0,0,1), E(0,1,1,1), E(1,1,1,1), E(2,1,1,1), E(3,1,1,0)};
    drop_tab = '{E(1,1,1,1), E(0,1,0,0), E(0,1,0,0)};
`else
    ss_tab   = '{E(4,0,1,1), E(4,0,1,0), E(4,0,1,0), E(4,0,1,0)};
    rev_tab  = '{E(4,0,1,1), E(0,0,0,1), E(0,0,0,1), E(0,1,1,1), E(3,1,1,0),
                 E(3,1,1,0), E(3,1,1,0), E(3,1,1,0), E(3,1,1,0), E(3,1,1,0)};
    drop_tab = '{E(0,1,0,0), E(0,1,0,0), E(0,1,0,0)};
`endif
    // reset held 2 cycles, with pwm_step high to show reset wins
    rst = 1'b1; ena = 1'b0; pwm_step = 1'b1; target_duty = '0; target_dir = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0; pwm_step = 1'b0; chk_en = 1'b1;
    lit("reset", 0, E(0,0,0,0));
    lit("reset", 1, E(0,0,0,0));

    ena = 1'b1; target_duty = 4'd4; target_dir = 1'b0;
    for (int k = 0; k < 4; k++) begin
      do_step(1);
      lit($sformatf("softstart%0d", k), 0, ss_tab[k]);
    end
    do_step(1);
    lit("hold4", 0, E(4,0,1,0));

    target_dir = 1'b1; target_duty = 4'd3;
    for (int k = 0; k < 10; k++) begin
      do_step(1);
      lit($sformatf("reversal%0d", k), 0, rev_tab[k]);
    end

    ena = 1'b0;
    do_step(3);
    ena = 1'b1; target_duty = 4'd5;
    do_step(2);
    ena = 1'b0;
    for (int k = 0; k < 3; k++) begin
      do_step(1);
      lit($sformatf("enadrop%0d", k), 0, drop_tab[k]);
    end

    ena = 1'b1; target_duty = 4'd3; target_dir = 1'b0;
    do_step(3);
    target_dir = 1'b1; ena = 1'b0;
    do_step(6);
    lit("brake_enadrop", 0, E(0,1,0,0));
    do_step(3);

    // saturation on the RAMP_STEP=3 instance
    ena = 1'b1; target_dir = 1'b0; target_duty = 4'd14;
    do_step(5);
    lit("sat14", 1, E(14,0,1,0));
    target_duty = 4'd15;
    do_step(1);
    lit("sat15", 1, E(15,0,1,0));
    target_duty = 4'd2;
    do_step(5);
    lit("sat2", 1, E(2,0,1,0));
    target_duty = 4'd0;
    do_step(1);
    lit("sat0", 1, E(0,0,0,0));
    do_step(2);

    target_duty = 4'd6;
    do_step(6);
    target_dir = 1'b1;
    do_step(2);
`ifdef PWM_SOFTSTART_EN
    lit("braking", 0, E(5,0,1,1));
`else
    lit("braking", 0, E(0,0,0,1));
`endif
    rst = 1'b1; pwm_step = 1'b1;
    @(negedge clk);
    lit("rst_brake", 0, E(0,0,0,0));
    lit("rst_brake", 1, E(0,0,0,0));
    rst = 1'b0; pwm_step = 1'b0;

    target_dir = 1'b0; target_duty = 4'd9;
    do_step(1);
`ifdef PWM_SOFTSTART_EN
    lit("jump9", 0, E(1,0,1,1));
`else
    lit("jump9", 0, E(9,0,1,1));
`endif
    do_step(3);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/pwm_ramp_ctrl.md
# pwm_ramp_ctrl

Sequencing controller for the H-bridge PWM datapath. It drives the duty word, direction bit and drive gate that feed the `pwm_out_A`/`pwm_out_B` generator. Duty changes are applied only at PWM period boundaries and are soft-ramped. A direction reversal always ramps to zero, then holds a dead time with both outputs off, so the bridge never sees a hard reversal. It sits between the user-facing control logic (buttons/targets) and the PWM counter/comparator in `main`.

## Interface
- `N`, 4: duty width in bits; matches the PWM comparator width.
- `RAMP_STEP`, 1: duty change per PWM period while ramping; must satisfy 1 ≤ `RAMP_STEP` ≤ 2^N−1.
- `DEAD_PERIODS`, 2: number of PWM periods with the drive off between directions; must be ≥ 1 (elaboration assertion).

- `clk`  in  1  system clock (12 MHz)
- `rst`  in  1  reset, synchronous, active-high
- `ena`  in  1  run request; deasserting it causes a ramp-down to IDLE
- `pwm_step`  in  1  one-cycle pulse at each PWM period start
- `target_duty`  in  N  requested duty
- `target_dir`  in  1  requested direction (0 = A, 1 = B)
- `duty`  out  N  duty word to the comparator
- `dir`  out  1  active direction select
- `drive_ena`  out  1  gate for `pwm_out_A`/`pwm_out_B`
- `busy`  out  1  high while in RAMP, BRAKE or DEAD

## Operation
- States: IDLE, RAMP, HOLD, BRAKE, DEAD.
- All state, `duty`, `dir` and `drive_ena` updates occur only on cycles with `pwm_step`=1.
- Inputs are sampled on those cycles only. Between pulses, input changes are ignored.
- Effective target: `target_duty` when `ena`=1, otherwise 0.
- **IDLE**
  - duty=0, drive_ena=0.
  - On step with effective target ≠ 0: dir←target_dir, drive_ena←1, apply the first ramp increment, go to RAMP.
- **RAMP**
  - If target_dir ≠ dir and duty ≠ 0: go to BRAKE, with no duty update this step.
  - Otherwise move duty toward the effective target by `RAMP_STEP`, saturating at the target (never overshoot).
  - If the new duty equals the target and is nonzero: go to HOLD.
  - If the new duty equals the target and the target is 0: go to IDLE, drive_ena←0, no dead time.
- **HOLD**
  - On step, if the effective target ≠ duty, or target_dir ≠ dir: re-evaluate as RAMP on the same step.
- **BRAKE**
  - duty decreases by `RAMP_STEP` per step, saturating at 0.
  - On reaching 0: drive_ena←0, dead counter←`DEAD_PERIODS`, go to DEAD.
- **DEAD**
  - Decrement the counter per step.
  - At the step that takes the counter from 1 to 0: dir←target_dir.
  - If the effective target ≠ 0: drive_ena←1, go to RAMP with no duty increment on this step.
  - Otherwise go to IDLE.
- **Arithmetic**
  - Unsigned; differences and sums are computed in N+1 bits.
  - duty never wraps and stays within [0, 2^N−1].
- **ena drop**
  - In RAMP/HOLD with the same direction: ramp to 0, then go to IDLE.
  - In BRAKE/DEAD: finish the sequence, then go to IDLE.

## Timing
- All outputs are registered. An update sampled on a `pwm_step` cycle is visible the following cycle.
- Reset values: duty=0, dir=0, drive_ena=0, busy=0, state=IDLE, dead counter=0.
- `rst` mid-operation takes effect on the next edge with no ramp-down. It overrides `pwm_step`.
- Latency from target change to first duty change: at most one PWM period.
- Full reversal at duty D: ⌈D/RAMP_STEP⌉ periods of braking, then `DEAD_PERIODS` periods off.
- `busy` is combinational from the state register, so it has the same timing as the state.

## Configuration
- `PWM_SOFTSTART_EN` defined: duty ramps as described above.
- `PWM_SOFTSTART_EN` undefined:
  - RAMP sets duty to the target in one step.
  - BRAKE sets duty to 0 in one step and moves to DEAD on that same step.
  - The dead time is retained.

## Structure
- Shared package `pwm_pkg`:
  - `ctrl_state_t` enum (IDLE, RAMP, HOLD, BRAKE, DEAD)
  - `pwm_dir_t`
  - default `N` and `DEAD_PERIODS` constants
- One sub-module, `dead_timer`: a loadable down-counter advanced by `pwm_step`, with a `done` pulse on the 1→0 transition.

## Test plan
(N=4, RAMP_STEP=1, DEAD_PERIODS=2, soft start enabled unless noted)
- **Reset:** rst high for 2 cycles → duty=0, dir=0, drive_ena=0, busy=0.
- **Soft start:** ena=1, target 4, dir 0 → duty 1,2,3,4 on successive steps; drive_ena=1 from the first step; busy=0 after 4.
- **Reversal:** from HOLD at 4, target_dir=1, target 3 → duty 3,2,1,0, then drive_ena=0 for 2 steps, then dir=1, then duty 1,2,3.
- **Saturation:** RAMP_STEP=3, duty 14 → target 15 gives 15 with no wrap; duty 2 → target 0 gives 0, then IDLE.
- **Enable drop:** ena=0 mid-ramp at duty 2 → duty 1, then 0, then IDLE; busy=0.
- **Reset and jump:** rst during BRAKE → all outputs 0 next cycle. With `PWM_SOFTSTART_EN` undefined, target 9 from IDLE gives duty 0→9 in one step.
